multdiv_iter: RTL
=================

// Module: multdiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit, successor to the fixed 32-bit multdiv.
//  Adds signed/unsigned mode, remainder and high product, a busy flag, and a deterministic latency.
//  Sits beside the ALU in the execute stage; the pipeline stalls on busy and resumes on data_resultRDY.
// PARAMETERS
//  WIDTH   32  operand/result width in bits, >=4, even
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived; not overridden)
// PORTS
//  clock          in   1      sole clock; rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  data_operandA  in   WIDTH  multiplicand / dividend; sampled on the start edge only
//  data_operandB  in   WIDTH  multiplier / divisor; sampled on the start edge only
//  ctrl_MULT      in   1      start-multiply pulse; honoured only in IDLE
//  ctrl_DIV       in   1      start-divide pulse; honoured only in IDLE
//  ctrl_SIGNED    in   1      1 = two's-complement operands; sampled with the start pulse
//  data_result    out  WIDTH  low product / quotient
//  data_remainder out  WIDTH  remainder; 0 after a multiply
//  data_exception out  1      overflow or divide-by-zero; valid while data_resultRDY=1
//  data_resultRDY out  1      single-cycle completion pulse
//  busy           out  1      1 from the start edge to the DONE cycle, inclusive
// BEHAVIOUR
//  Reset: state=IDLE; every output is 0; counter=0.
//  FSM states: IDLE -> RUN (WIDTH cycles) -> FIX (1 cycle) -> DONE (1 cycle) -> IDLE.
//  Start edge: operands are converted to magnitudes (if ctrl_SIGNED) and latched; sign flags are latched.
//  Start priority: ctrl_MULT and ctrl_DIV both high -> MULT; the DIV request is dropped.
//  Start pulses while busy=1 are ignored; the operation in flight is unaffected.
//  RUN, multiply: radix-2 shift-add on magnitudes; the full 2*WIDTH product is kept.
//  RUN, divide: restoring shift-subtract on magnitudes, one quotient bit per cycle.
//  FIX: negate the results when signs are applied.
//   - Product sign = signA ^ signB.
//   - Quotient sign = signA ^ signB; remainder sign = signA (truncating division).
//  DONE: data_resultRDY=1 for exactly one cycle. Results and exception hold until the next start edge.
//  Latency: start on edge N -> data_resultRDY high in the cycle after edge N+WIDTH+1; fixed for every case.
//  Multiply overflow: exception=1 when the 2W product is not representable in W bits.
//   - Signed: the high half is not the sign-extension of bit W-1.
//   - Unsigned: the high half is nonzero.
//   - data_result = low W bits (wrapped).
//  Divide by zero: exception=1; data_result=0; data_remainder=dividend; full latency is still used.
//  Signed MIN/-1: exception=1; data_result=MIN (wrapped); data_remainder=0.
//  0/x is not an exception: the result is 0.
//  Reset asserted mid-operation: the FSM aborts to IDLE, no resultRDY pulse is issued, and the outputs clear.
//  Start in the same cycle as DONE: ignored (busy=1); a start is accepted from the next cycle onward.
// CONFIGURATION
//  MULTDIV_HIGH_RESULT_EN defined:
//   - Adds output data_result_hi [WIDTH], the high half of the product (0 after a divide).
//   - Held on the same schedule as data_result.
//  MULTDIV_HIGH_RESULT_EN undefined:
//   - The port is absent and the high half is used only for overflow detection.
//  Latency is identical with and without the macro.
// STRUCTURE
//  multdiv_pkg holds:
//   - state enum {IDLE, RUN, FIX, DONE};
//   - op enum {OP_MULT, OP_DIV};
//   - a function for the WIDTH-bit two's-complement negate/abs.
//  Sub-module multdiv_cycle_counter: loadable down-counter (CNT_W) with async clear; its terminal flag ends RUN.
//  The datapath (accumulator, shift register, single WIDTH+1 adder/subtractor shared by both ops) lives in the top.
// TESTING (WIDTH=32)
//  1. MULT signed 7 x -3 -> result 0xFFFFFFEB, exc=0, resultRDY exactly 34 cycles after start.
//  2. MULT unsigned 0x00010000 x 0x00010000 -> result 0, exc=1 (with macro: result_hi=1).
//  3. DIV signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, exc=0.
//  4. DIV 5 / 0 -> result 0, remainder 5, exc=1. DIV signed 0x80000000 / -1 -> 0x80000000, exc=1.
//  5. ctrl_DIV pulse at cycle 10 of a MULT -> ignored; a single resultRDY carries the MULT result; busy stays 1.
//  6. reset asserted at cycle 15 of a DIV -> all outputs 0 at once, no resultRDY; new MULT 3x4 after release -> 12.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared state/op encodings and the conditional negate used for abs() and sign fix-up.
package multdiv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    typedef enum logic {OP_MULT, OP_DIV} op_t;

    localparam int MD_MAX_W = 128;

    // Callers zero-extend into MD_MAX_W and cast the result back to their own width.
    function automatic logic [MD_MAX_W-1:0] md_cneg(input logic [MD_MAX_W-1:0] v, input logic en);
        return en ? (~v + {{(MD_MAX_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Loadable down-counter with async clear; o_term marks the last iteration cycle.
module multdiv_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_term
);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_term = (r_cnt == ONE);

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply/divide; define MULTDIV_HIGH_RESULT_EN to expose the high product half.
// Fixed WIDTH+2 cycle latency; start pulses are ignored (not queued) while busy.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef MULTDIV_HIGH_RESULT_EN
    output logic [WIDTH-1:0] data_result_hi,
`endif
    output logic             busy
);
    localparam int PW = 2 * WIDTH;

    state_t           r_state;
    op_t              r_op;
    logic             r_signed, r_sign_a, r_sign_b;
    logic [WIDTH-1:0] r_acc, r_q, r_opd;
    logic [WIDTH-1:0] r_result, r_remainder;
    logic             r_exception, r_rdy, r_busy;
`ifdef MULTDIV_HIGH_RESULT_EN
    logic [WIDTH-1:0] r_result_hi;
`endif

    logic             w_start, w_start_mult, w_sign_a, w_sign_b, w_is_div, w_cnt_term;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_quot, w_rem;
    logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
    logic [PW-1:0]    w_prod;
    logic             w_mul_ovf, w_div_zero, w_div_ovf;

    assign w_start      = (r_state == IDLE) && (ctrl_MULT || ctrl_DIV);
    assign w_start_mult = ctrl_MULT;
    assign w_sign_a     = ctrl_SIGNED & data_operandA[WIDTH-1];
    assign w_sign_b     = ctrl_SIGNED & data_operandB[WIDTH-1];
    assign w_mag_a      = WIDTH'(md_cneg(MD_MAX_W'(data_operandA), w_sign_a));
    assign w_mag_b      = WIDTH'(md_cneg(MD_MAX_W'(data_operandB), w_sign_b));

    // One shared adder: acc + multiplicand for multiply, (remainder:next bit) - divisor for divide.
    assign w_is_div = (r_op == OP_DIV);
    assign w_add_a  = w_is_div ? {r_acc, r_q[WIDTH-1]} : {1'b0, r_acc};
    assign w_add_b  = w_is_div ? ~{1'b0, r_opd} : {1'b0, r_opd};
    assign w_sum    = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_is_div};

    assign w_prod     = PW'(md_cneg(MD_MAX_W'({r_acc, r_q}), r_sign_a ^ r_sign_b));
    assign w_quot     = WIDTH'(md_cneg(MD_MAX_W'(r_q), r_sign_a ^ r_sign_b));
    assign w_rem      = WIDTH'(md_cneg(MD_MAX_W'(r_acc), r_sign_a));
    assign w_mul_ovf  = r_signed ? (w_prod[PW-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
                                 : (w_prod[PW-1:WIDTH] != '0);
    assign w_div_zero = (r_opd == '0);
    // Only MIN / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
    assign w_div_ovf  = r_signed & r_q[WIDTH-1] &
                        ~((r_sign_a ^ r_sign_b) & (r_q[WIDTH-2:0] == '0));

    multdiv_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_load     (w_start),
        .i_load_val (CNT_W'(WIDTH)),
        .i_dec      (r_state == RUN),
        .o_term     (w_cnt_term)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= OP_MULT;
            r_signed    <= 1'b0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_acc       <= '0;
            r_q         <= '0;
            r_opd       <= '0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MULTDIV_HIGH_RESULT_EN
            r_result_hi <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state  <= RUN;
                        r_busy   <= 1'b1;
                        r_op     <= w_start_mult ? OP_MULT : OP_DIV;
                        r_signed <= ctrl_SIGNED;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_acc    <= '0;
                        r_q      <= w_start_mult ? w_mag_b : w_mag_a;
                        r_opd    <= w_start_mult ? w_mag_a : w_mag_b;
                    end
                end
                RUN: begin
                    if (!w_is_div) begin
                        if (r_q[0]) {r_acc, r_q} <= {w_sum, r_q[WIDTH-1:1]};
                        else        {r_acc, r_q} <= {1'b0, r_acc, r_q[WIDTH-1:1]};
                    end else if (!w_sum[WIDTH]) begin
                        r_acc <= w_sum[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    if (w_cnt_term) r_state <= FIX;
                end
                FIX: begin
                    r_state     <= DONE;
                    r_rdy       <= 1'b1;
                    r_result    <= !w_is_div ? w_prod[WIDTH-1:0] : (w_div_zero ? '0 : w_quot);
                    r_remainder <= !w_is_div ? '0 : w_rem;
                    r_exception <= !w_is_div ? w_mul_ovf : (w_div_zero | w_div_ovf);
`ifdef MULTDIV_HIGH_RESULT_EN
                    r_result_hi <= !w_is_div ? w_prod[PW-1:WIDTH] : '0;
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;
`ifdef MULTDIV_HIGH_RESULT_EN
    assign data_result_hi = r_result_hi;
`endif

endmodule
